// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: valid/ready request in, LATENCY wait states, valid/ready response out.
// Optional build macro DMEM_BYTE_LANE_EN enables per-byte store lanes from req_be; otherwise stores write the full word.

module dmem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    // state | meaning
    // IDLE  | ready for a request (req_ready=1)
    // WAIT  | counting wait states down to terminal count 0
    // RESP  | response presented (rsp_valid=1) until rsp_ready

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic [3:0] wait_cnt, wait_cnt_nxt;

    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_be;

    logic             accept;
    logic             commit;
    logic             src_we;
    logic [31:0]      src_addr;
    logic [31:0]      src_wdata;
    logic [3:0]       src_be;
    logic             src_err;
    logic [IDX_W-1:0] src_idx;
    logic [3:0]       lane_en;
    logic [31:0]      wr_mask;
    logic [31:0]      mem_word;

    logic [31:0] mem [DEPTH];

    assign req_ready = (state == IDLE) & ~reset;
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid & req_ready;

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 0) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt    = WAIT;
                        wait_cnt_nxt = LAT_M1;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_nxt = RESP;
                end else begin
                    wait_cnt_nxt = wait_cnt - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // With zero latency the commit edge is also the accept edge, so the
    // request is taken straight from the ports rather than the latch.
    always_comb begin
        if (state == IDLE) begin
            src_we    = req_we;
            src_addr  = req_addr;
            src_wdata = req_wdata;
            src_be    = req_be;
        end else begin
            src_we    = lat_we;
            src_addr  = lat_addr;
            src_wdata = lat_wdata;
            src_be    = lat_be;
        end
    end

    assign commit   = ~reset & (state != RESP) & (state_nxt == RESP);
    assign src_err  = (src_addr[1:0] != 2'b00) || ({2'b00, src_addr[31:2]} >= 32'(DEPTH));
    assign src_idx  = src_addr[IDX_W+1:2];
    assign mem_word = mem[src_idx];

`ifdef DMEM_BYTE_LANE_EN
    assign lane_en = src_be;
`else
    // All lanes forced on; be is folded in only so the port stays referenced.
    assign lane_en = src_be | 4'hF;
`endif

    assign wr_mask = {{8{lane_en[3]}}, {8{lane_en[2]}}, {8{lane_en[1]}}, {8{lane_en[0]}}};

    always_ff @(posedge clk) begin
        if (commit && src_we && !src_err) begin
            mem[src_idx] <= (mem_word & ~wr_mask) | (src_wdata & wr_mask);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            lat_we    <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            lat_be    <= 4'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (accept) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_be    <= req_be;
            end
            if (commit) begin
                rsp_err   <= src_err;
                rsp_rdata <= (src_we || src_err) ? 32'd0 : mem_word;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 instance for function/timing, LATENCY=0 instance for throughput.
// Byte-lane expectation follows DMEM_BYTE_LANE_EN.

module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic        z_req_valid, z_req_ready, z_req_we;
    logic [31:0] z_req_addr, z_req_wdata;
    logic [3:0]  z_req_be;
    logic        z_rsp_valid, z_rsp_ready;
    logic [31:0] z_rsp_rdata;
    logic        z_rsp_err;

    int checks   = 0;
    int failures = 0;

`ifdef DMEM_BYTE_LANE_EN
    localparam logic [31:0] BL_EXP = 32'hFF00FF00;
`else
    localparam logic [31:0] BL_EXP = 32'h00000000;
`endif

    dmem_responder #(.DEPTH(64), .LATENCY(2)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    dmem_responder #(.DEPTH(64), .LATENCY(0)) u_dut_z (
        .clk       (clk),
        .reset     (reset),
        .req_valid (z_req_valid),
        .req_ready (z_req_ready),
        .req_we    (z_req_we),
        .req_addr  (z_req_addr),
        .req_wdata (z_req_wdata),
        .req_be    (z_req_be),
        .rsp_valid (z_rsp_valid),
        .rsp_ready (z_rsp_ready),
        .rsp_rdata (z_rsp_rdata),
        .rsp_err   (z_rsp_err)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Starts and ends on a falling edge; rsp_ready held high.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output logic [31:0] rdata, output logic err,
                          output int lat);
        int n;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("req_ready_wait", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'h5555_5555;
        lat = 1;
        while (!rsp_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        rdata = rsp_rdata;
        err   = rsp_err;
        @(negedge clk);
    endtask

    task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input logic [31:0] exp_rd, input logic exp_err);
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(we, addr, wdata, be, rd, er, lat);
        check_val({tag, "_rdata"}, rd, exp_rd);
        check_val({tag, "_err"}, 32'(er), 32'(exp_err));
        check_val({tag, "_lat"}, 32'(lat), 32'd3);
    endtask

    logic        z_we   [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] z_addr [4] = '{32'h4, 32'h4, 32'h7, 32'h4};
    logic [31:0] z_wd   [4] = '{32'hCAFEF00D, 32'h0, 32'h0, 32'h0};
    logic [31:0] z_exp  [4] = '{32'h0, 32'hCAFEF00D, 32'h0, 32'hCAFEF00D};
    logic        z_eerr [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_addr    = 32'd0;
        req_wdata   = 32'd0;
        req_be      = 4'd0;
        rsp_ready   = 1'b0;
        z_req_valid = 1'b0;
        z_req_we    = 1'b0;
        z_req_addr  = 32'd0;
        z_req_wdata = 32'd0;
        z_req_be    = 4'hF;
        z_rsp_ready = 1'b0;

        repeat (2) @(negedge clk);
        check_val("rst_req_ready", 32'(req_ready), 32'd0);
        check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("rst_rsp_rdata", rsp_rdata, 32'd0);
        check_val("rst_rsp_err",   32'(rsp_err), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_val("idle_req_ready", 32'(req_ready), 32'd1);

        // read after write
        txn("st10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        txn("ld10", 1'b0, 32'h10, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0);

        // byte lanes
        txn("st20a", 1'b1, 32'h20, 32'hFFFFFFFF, 4'hF,    32'h0, 1'b0);
        txn("st20b", 1'b1, 32'h20, 32'h00000000, 4'b0101, 32'h0, 1'b0);
        txn("ld20",  1'b0, 32'h20, 32'h0,        4'hF,    BL_EXP, 1'b0);

        // errors and boundary index
        txn("st00",  1'b1, 32'h00,  32'hA5A5A5A5, 4'hF, 32'h0, 1'b0);
        txn("ld13",  1'b0, 32'h13,  32'h0,        4'hF, 32'h0, 1'b1);
        txn("st100", 1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
        txn("ld00",  1'b0, 32'h00,  32'h0,        4'hF, 32'hA5A5A5A5, 1'b0);
        txn("stFC",  1'b1, 32'hFC,  32'h11223344, 4'hF, 32'h0, 1'b0);
        txn("ldFC",  1'b0, 32'hFC,  32'h0,        4'hF, 32'h11223344, 1'b0);
        txn("ld100", 1'b0, 32'h100, 32'h0,        4'hF, 32'h0, 1'b1);

        // backpressure with req_valid held and inputs changed after accept
        txn("st30", 1'b1, 32'h30, 32'h0BADF00D, 4'hF, 32'h0, 1'b0);
        req_we    = 1'b0;
        req_addr  = 32'h30;
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_addr  = 32'h13;
        req_we    = 1'b1;
        n = 1;
        while (!rsp_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check_val("bp_lat", 32'(n), 32'd3);
        for (int i = 0; i < 5; i++) begin
            check_val($sformatf("bp%0d_valid", i), 32'(rsp_valid), 32'd1);
            check_val($sformatf("bp%0d_rdata", i), rsp_rdata, 32'h0BADF00D);
            check_val($sformatf("bp%0d_err", i),   32'(rsp_err), 32'd0);
            check_val($sformatf("bp%0d_ready", i), 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        check_val("bp_done_valid", 32'(rsp_valid), 32'd0);
        check_val("bp_done_ready", 32'(req_ready), 32'd1);

        // reset during WAIT discards the uncommitted store
        txn("st08", 1'b1, 32'h08, 32'hAAAAAAAA, 4'hF, 32'h0, 1'b0);
        txn("ld08", 1'b0, 32'h08, 32'h0,        4'hF, 32'hAAAAAAAA, 1'b0);
        req_we    = 1'b1;
        req_addr  = 32'h08;
        req_wdata = 32'h12345678;
        req_be    = 4'hF;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check_val("mid_wait_ready", 32'(req_ready), 32'd0);
        reset = 1'b1;
        #1;
        check_val("mr_req_ready", 32'(req_ready), 32'd0);
        check_val("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("mr_rsp_rdata", rsp_rdata, 32'd0);
        check_val("mr_rsp_err",   32'(rsp_err), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        txn("ld08_after", 1'b0, 32'h08, 32'h0, 4'hF, 32'hAAAAAAAA, 1'b0);

        // zero latency: req_valid and rsp_ready held high, one accept every 2 cycles
        z_rsp_ready = 1'b1;
        z_req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                check_val($sformatf("z%0d_valid", i), 32'(z_rsp_valid), 32'd0);
                check_val($sformatf("z%0d_ready", i), 32'(z_req_ready), 32'd1);
                z_req_we    = z_we[i/2];
                z_req_addr  = z_addr[i/2];
                z_req_wdata = z_wd[i/2];
            end else begin
                check_val($sformatf("z%0d_valid", i), 32'(z_rsp_valid), 32'd1);
                check_val($sformatf("z%0d_ready", i), 32'(z_req_ready), 32'd0);
                check_val($sformatf("z%0d_rdata", i), z_rsp_rdata, z_exp[i/2]);
                check_val($sformatf("z%0d_err", i),   32'(z_rsp_err), 32'(z_eerr[i/2]));
            end
            @(negedge clk);
        end
        z_req_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
